// File: rtl/ip_rx_serializer_pkg.sv
// Shared constants for the IP receive serializer: FSM encoding, prefix length
// and header sanity limits.
package ip_rx_serializer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PREFIX  = 2'd1;
  localparam state_t ST_PAYLOAD = 2'd2;
  localparam state_t ST_DRAIN   = 2'd3;

  localparam int         PREFIX_LEN = 12;
  localparam int         MF_BIT     = 0;
  localparam logic [3:0] MIN_IHL    = 4'd5;

  // Payload length = total length minus header length (IHL counts 32-bit words).
  function automatic logic [15:0] payload_len(input logic [15:0] length,
                                              input logic [3:0]  ihl);
    return length - {10'd0, ihl, 2'b00};
  endfunction

endpackage

// File: rtl/ip_rx_serializer.sv
// Turns an IP header plus AXIS payload into a byte stream for an external FIFO:
// a 12-byte metadata prefix followed by the IP payload, Ethernet padding removed.
//
// state   | meaning
// IDLE    | waiting for a header; only state with rx_hdr_ready=1
// PREFIX  | emitting the 12 prefix bytes, payload held off
// PAYLOAD | passing payload bytes through while remaining > 0
// DRAIN   | discarding beats up to tlast (padding or dropped packet)
module ip_rx_serializer
  import ip_rx_serializer_pkg::*;
#(
  parameter bit         FILTER_EN    = 1'b1,
  parameter logic [7:0] FILTER_PROTO = 8'd17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_hdr_valid,
  output logic        rx_hdr_ready,
  input  logic [3:0]  rx_ip_ihl,
  input  logic [15:0] rx_ip_length,
  input  logic [2:0]  rx_ip_flags,
  input  logic [12:0] rx_ip_fragment_offset,
  input  logic [7:0]  rx_ip_ttl,
  input  logic [7:0]  rx_ip_protocol,
  input  logic [31:0] rx_ip_source_ip,
  input  logic [31:0] rx_ip_dest_ip,
  input  logic [7:0]  rx_payload_tdata,
  input  logic        rx_payload_tvalid,
  output logic        rx_payload_tready,
  input  logic        rx_payload_tlast,
  output logic [7:0]  dout_din,
  output logic        dout_write,
  input  logic        dout_full_n,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
);

  localparam logic [3:0] LAST_IDX = 4'(PREFIX_LEN - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [15:0] remaining;
  logic [15:0] plen_q;
  logic [7:0]  proto_q;
  logic [7:0]  ttl_q;
  logic [31:0] src_q;
  logic [31:0] dst_q;

  logic        hdr_accept;
  logic        hdr_drop;
  logic [7:0]  prefix_byte;
  logic        flags_unused;

  assign flags_unused = ^rx_ip_flags[2:1];

  assign rx_hdr_ready = (state == ST_IDLE);
  assign hdr_accept   = rx_hdr_valid & rx_hdr_ready;

  assign hdr_drop = (rx_ip_ihl < MIN_IHL)
                  | (rx_ip_length < {10'd0, rx_ip_ihl, 2'b00})
                  | rx_ip_flags[MF_BIT]
                  | (rx_ip_fragment_offset != 13'd0)
                  | (FILTER_EN && (rx_ip_protocol != FILTER_PROTO));

  always_comb begin
    case (idx)
      4'd0:    prefix_byte = plen_q[15:8];
      4'd1:    prefix_byte = plen_q[7:0];
      4'd2:    prefix_byte = proto_q;
      4'd3:    prefix_byte = ttl_q;
      4'd4:    prefix_byte = src_q[31:24];
      4'd5:    prefix_byte = src_q[23:16];
      4'd6:    prefix_byte = src_q[15:8];
      4'd7:    prefix_byte = src_q[7:0];
      4'd8:    prefix_byte = dst_q[31:24];
      4'd9:    prefix_byte = dst_q[23:16];
      4'd10:   prefix_byte = dst_q[15:8];
      4'd11:   prefix_byte = dst_q[7:0];
      default: prefix_byte = 8'h00;
    endcase
  end

  always_comb begin
    rx_payload_tready = 1'b0;
    dout_write        = 1'b0;
    dout_din          = 8'h00;
    case (state)
      ST_PREFIX: begin
        dout_write = dout_full_n;
        dout_din   = prefix_byte;
      end
      ST_PAYLOAD: begin
        rx_payload_tready = dout_full_n;
        dout_write        = rx_payload_tvalid & dout_full_n;
        dout_din          = rx_payload_tdata;
      end
      ST_DRAIN: rx_payload_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= 4'd0;
      remaining  <= 16'd0;
      plen_q     <= 16'd0;
      proto_q    <= 8'd0;
      ttl_q      <= 8'd0;
      src_q      <= 32'd0;
      dst_q      <= 32'd0;
      pkt_count  <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hdr_accept) begin
            plen_q    <= payload_len(rx_ip_length, rx_ip_ihl);
            remaining <= payload_len(rx_ip_length, rx_ip_ihl);
            proto_q   <= rx_ip_protocol;
            ttl_q     <= rx_ip_ttl;
            src_q     <= rx_ip_source_ip;
            dst_q     <= rx_ip_dest_ip;
            idx       <= 4'd0;
            if (hdr_drop) begin
              state      <= ST_DRAIN;
              drop_count <= drop_count + 16'd1;
            end else begin
              state <= ST_PREFIX;
            end
          end
        end
        ST_PREFIX: begin
          if (dout_full_n) begin
            if (idx == LAST_IDX) begin
              idx       <= 4'd0;
              pkt_count <= pkt_count + 16'd1;
              state     <= (plen_q != 16'd0) ? ST_PAYLOAD : ST_DRAIN;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (dout_write) begin
            remaining <= remaining - 16'd1;
            // Last IP byte without tlast means Ethernet padding still follows.
            if (remaining == 16'd1)
              state <= rx_payload_tlast ? ST_IDLE : ST_DRAIN;
            else if (rx_payload_tlast)
              state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (rx_payload_tvalid && rx_payload_tlast)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_rx_serializer.sv
// Directed bench for ip_rx_serializer: captures every FIFO write and compares the
// stream and counters against hand-computed expectations.
module tb_ip_rx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_hdr_valid = 1'b0;
  logic        rx_hdr_ready;
  logic [3:0]  rx_ip_ihl = 4'd0;
  logic [15:0] rx_ip_length = 16'd0;
  logic [2:0]  rx_ip_flags = 3'd0;
  logic [12:0] rx_ip_fragment_offset = 13'd0;
  logic [7:0]  rx_ip_ttl = 8'd0;
  logic [7:0]  rx_ip_protocol = 8'd0;
  logic [31:0] rx_ip_source_ip = 32'd0;
  logic [31:0] rx_ip_dest_ip = 32'd0;
  logic [7:0]  rx_payload_tdata = 8'd0;
  logic        rx_payload_tvalid = 1'b0;
  logic        rx_payload_tready;
  logic        rx_payload_tlast = 1'b0;
  logic [7:0]  dout_din;
  logic        dout_write;
  logic        dout_full_n = 1'b1;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  int beats = 0;
  int wr_while_full = 0;
  bit rand_full = 1'b0;

  ip_rx_serializer #(.FILTER_EN(1'b1), .FILTER_PROTO(8'd17)) dut (
    .clk(clk), .rst(rst),
    .rx_hdr_valid(rx_hdr_valid), .rx_hdr_ready(rx_hdr_ready),
    .rx_ip_ihl(rx_ip_ihl), .rx_ip_length(rx_ip_length),
    .rx_ip_flags(rx_ip_flags), .rx_ip_fragment_offset(rx_ip_fragment_offset),
    .rx_ip_ttl(rx_ip_ttl), .rx_ip_protocol(rx_ip_protocol),
    .rx_ip_source_ip(rx_ip_source_ip), .rx_ip_dest_ip(rx_ip_dest_ip),
    .rx_payload_tdata(rx_payload_tdata), .rx_payload_tvalid(rx_payload_tvalid),
    .rx_payload_tready(rx_payload_tready), .rx_payload_tlast(rx_payload_tlast),
    .dout_din(dout_din), .dout_write(dout_write), .dout_full_n(dout_full_n),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO back-pressure driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      dout_full_n = rand_full ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor on the falling edge: what is seen here commits at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (dout_write) begin
        cap.push_back(dout_din);
        if (!dout_full_n) wr_while_full++;
      end
      if (rx_payload_tvalid && rx_payload_tready) beats++;
    end
  end

  task automatic clear_capture();
    cap.delete();
    beats = 0;
    wr_while_full = 0;
  endtask

  task automatic send_hdr(input logic [3:0] ihl, input logic [15:0] len,
                          input logic [2:0] flags, input logic [12:0] frag,
                          input logic [7:0] proto);
    bit got;
    rx_ip_ihl = ihl;
    rx_ip_length = len;
    rx_ip_flags = flags;
    rx_ip_fragment_offset = frag;
    rx_ip_ttl = 8'd64;
    rx_ip_protocol = proto;
    rx_ip_source_ip = 32'hC0A80101;
    rx_ip_dest_ip = 32'hC0A80164;
    rx_hdr_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (rx_hdr_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_hdr_valid = 1'b0;
    if (!got) check_val("hdr_accept_timeout", 0, 1);
  endtask

  task automatic send_beats(input int n);
    bit got;
    for (int i = 0; i < n; i++) begin
      rx_payload_tdata = 8'(i + 1);
      rx_payload_tvalid = 1'b1;
      rx_payload_tlast = (i == n - 1);
      got = 1'b0;
      for (int c = 0; c < 500 && !got; c++) begin
        @(negedge clk);
        if (rx_payload_tready) got = 1'b1;
        @(posedge clk);
        #1;
      end
      if (!got) check_val("beat_timeout", i, n);
    end
    rx_payload_tvalid = 1'b0;
    rx_payload_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic build_udp_expected(input int npay);
    exp_q = '{8'h00, 8'h08, 8'h11, 8'h40, 8'hC0, 8'hA8, 8'h01, 8'h01,
              8'hC0, 8'hA8, 8'h01, 8'h64};
    for (int i = 1; i <= npay; i++) exp_q.push_back(8'(i));
  endtask

  task automatic compare_stream(input string tag);
    check_val({tag, "_len"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      check_val($sformatf("%s_b%0d", tag, i), cap[i], exp_q[i]);
  endtask

  initial begin
    // reset values
    @(negedge clk);
    check_val("rst_hdr_ready", rx_hdr_ready, 1);
    check_val("rst_tready", rx_payload_tready, 0);
    check_val("rst_write", dout_write, 0);
    check_val("rst_din", dout_din, 0);
    check_val("rst_pkt", pkt_count, 0);
    check_val("rst_drop", drop_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // basic UDP packet, payload 01..08
    clear_capture();
    send_hdr(4'd5, 16'd28, 3'd0, 13'd0, 8'd17);
    send_beats(8);
    build_udp_expected(8);
    compare_stream("udp");
    check_val("udp_pkt", pkt_count, 1);
    check_val("udp_beats", beats, 8);

    // 8 payload + 10 padding bytes, padding drained
    clear_capture();
    send_hdr(4'd5, 16'd28, 3'd0, 13'd0, 8'd17);
    send_beats(18);
    build_udp_expected(8);
    compare_stream("pad");
    check_val("pad_beats", beats, 18);
    check_val("pad_pkt", pkt_count, 2);

    // TCP filtered
    clear_capture();
    send_hdr(4'd5, 16'd25, 3'd0, 13'd0, 8'd6);
    send_beats(5);
    check_val("tcp_writes", cap.size(), 0);
    check_val("tcp_beats", beats, 5);
    check_val("tcp_drop", drop_count, 1);
    check_val("tcp_pkt", pkt_count, 2);

    // MF flag set
    clear_capture();
    send_hdr(4'd5, 16'd23, 3'b001, 13'd0, 8'd17);
    send_beats(3);
    check_val("mf_writes", cap.size(), 0);
    check_val("mf_drop", drop_count, 2);

    // non-zero fragment offset
    clear_capture();
    send_hdr(4'd5, 16'd23, 3'd0, 13'd3, 8'd17);
    send_beats(3);
    check_val("frag_writes", cap.size(), 0);
    check_val("frag_drop", drop_count, 3);

    // random back-pressure
    clear_capture();
    rand_full = 1'b1;
    send_hdr(4'd5, 16'd28, 3'd0, 13'd0, 8'd17);
    send_beats(8);
    rand_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    build_udp_expected(8);
    compare_stream("bp");
    check_val("bp_wr_while_full", wr_while_full, 0);
    check_val("bp_pkt", pkt_count, 3);

    // reset after 6 prefix bytes
    clear_capture();
    rx_payload_tdata = 8'hA5;
    rx_payload_tvalid = 1'b1;
    rx_payload_tlast = 1'b0;
    send_hdr(4'd5, 16'd28, 3'd0, 13'd0, 8'd17);
    begin
      bit six;
      six = 1'b0;
      for (int c = 0; c < 100 && !six; c++) begin
        if (cap.size() >= 6) six = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      if (!six) check_val("abort_timeout", cap.size(), 6);
    end
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_written", cap.size(), 6);
    check_val("abort_hdr_ready", rx_hdr_ready, 1);
    check_val("abort_tready", rx_payload_tready, 0);
    check_val("abort_write", dout_write, 0);
    check_val("abort_pkt", pkt_count, 0);
    check_val("abort_drop", drop_count, 0);
    check_val("abort_beats", beats, 0);
    rx_payload_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    clear_capture();
    send_hdr(4'd5, 16'd28, 3'd0, 13'd0, 8'd17);
    send_beats(8);
    build_udp_expected(8);
    compare_stream("post_rst");
    check_val("post_rst_pkt", pkt_count, 1);
    check_val("post_rst_drop", drop_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ip_rx_serializer.md
IP_RX_SERIALIZER -- requirements
Module: ip_rx_serializer

Interface
REQ-001 SHALL have parameter FILTER_EN, default 1; 1 = drop non-matching protocol.
REQ-002 SHALL have parameter FILTER_PROTO, default 17; IP protocol number accepted (UDP).
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rx_hdr_valid  in  1  IP header valid.
REQ-007 rx_hdr_ready  out  1  IP header accepted.
REQ-008 rx_ip_ihl / rx_ip_length / rx_ip_flags / rx_ip_fragment_offset  in  4/16/3/13  header fields.
REQ-009 rx_ip_ttl / rx_ip_protocol  in  8/8  header fields.
REQ-010 rx_ip_source_ip / rx_ip_dest_ip  in  32/32  header addresses.
REQ-011 rx_payload_tdata / tvalid / tready / tlast  in/in/out/in  8/1/1/1  AXIS payload bytes.
REQ-012 dout_din / dout_write / dout_full_n  out/out/in  8/1/1  byte FIFO write port.
REQ-013 pkt_count / drop_count  out  16/16  forwarded / dropped packet counters.

Function
REQ-014 SHALL be a byte serializer: each accepted packet becomes a 12-byte prefix followed by payload bytes on dout.
REQ-015 Prefix order SHALL be: length[15:8], length[7:0], protocol, ttl, source_ip bytes MSB first (4), dest_ip bytes MSB first (4).
REQ-016 Emitted length SHALL be the payload length P = rx_ip_length - 4*rx_ip_ihl, 16-bit.
REQ-017 States SHALL be IDLE, PREFIX, PAYLOAD, DRAIN.
REQ-018 rx_hdr_ready SHALL be 1 only in IDLE; header accept = valid & ready; all fields latched on accept.
REQ-019 A drop SHALL occur on accept when: ihl<5; or length<4*ihl; or MF flag (bit 0) set; or fragment_offset!=0; or FILTER_EN=1 and protocol!=FILTER_PROTO.
REQ-020 Transitions from IDLE on accept: dropped -> DRAIN, drop_count+1; otherwise -> PREFIX, index 0.
REQ-021 PREFIX: dout_write = dout_full_n and dout_din = prefix[index]; index advances only on write.
REQ-022 PREFIX exit: after byte 11 is written, go to PAYLOAD if P>0, otherwise DRAIN; pkt_count+1 on exit.
REQ-023 PAYLOAD: tready = dout_full_n; dout_write = tvalid & dout_full_n; dout_din = tdata (combinational pass-through).
REQ-024 PAYLOAD: the remaining count starts at P and decrements per write.
REQ-025 PAYLOAD on the write with remaining=1: tlast -> IDLE; otherwise -> DRAIN, because Ethernet padding follows.
REQ-026 PAYLOAD on tlast with remaining>1 (truncated): -> IDLE; no fill bytes are inserted.
REQ-027 DRAIN: tready=1 and dout_write=0; on a tvalid&tlast beat -> IDLE.
REQ-028 First prefix byte SHALL appear at the earliest in the cycle after header accept.
REQ-029 dout_full_n=0 SHALL stall without byte loss or duplication; a full_n toggle every cycle is legal.
REQ-030 Counters SHALL wrap modulo 2^16.
REQ-031 tready SHALL be 0 in IDLE and PREFIX; payload beats are never consumed before the prefix completes.

Reset
REQ-032 On rst: state=IDLE, index=0, remaining=0, pkt_count=0, drop_count=0, latched fields=0.
REQ-033 Output values in reset: rx_hdr_ready=1 (state IDLE), rx_payload_tready=0, dout_write=0, dout_din=0.
REQ-034 rst asserted mid-packet SHALL abort at once; the partial FIFO contents are not recalled and the upstream owns flushing.

Structure
REQ-035 A shared package (ip_rx_serializer_pkg) SHALL hold the state enum, PREFIX_LEN=12, the MF bit index and the minimum IHL=5.
REQ-036 SHALL be a single module; no sub-module. The FIFO is external (siso).

Verification
REQ-037 UDP, ihl=5, length=28, src 192.168.1.1, dst 192.168.1.100, ttl=64, 8 bytes 0x01..0x08 with tlast on last, full_n=1.
  Required dout: 00 08 11 40 C0 A8 01 01 C0 A8 01 64 01..08; pkt_count=1.
REQ-038 Same header, 8 payload + 10 padding bytes with tlast on byte 18 -> 20 bytes written; padding consumed in DRAIN; next header accepted.
REQ-039 Protocol=6 (TCP), 5-byte payload -> no dout writes; 5 beats consumed; drop_count=1.
REQ-040 MF flag=1 or fragment_offset=3 -> dropped; drop_count increments per packet.
REQ-041 full_n random 50% across REQ-037 traffic -> identical byte sequence; no write while full_n=0.
REQ-042 rst asserted after 6 prefix bytes -> next cycle is IDLE with tready=0 and counters 0; a following clean packet is serialized correctly.
